// File: rtl/mlaccel_mem_arbiter.sv
// Arbitrates the shared 64-bit memory between compute, host and sequencer clients.
// Command is registered one cycle after grant; done/rvalid pulses follow at fixed RD_LAT.
module mlaccel_mem_arbiter #(
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        c_ren,
    input  logic [7:0]  c_wen,
    input  logic [15:0] c_addr,
    input  logic [63:0] c_wdata,
    output logic        c_ready,
    output logic        c_rvalid,
    input  logic        h_valid,
    input  logic [1:0]  h_wen,
    input  logic [15:0] h_addr,
    input  logic [15:0] h_wdata,
    output logic        h_done,
    output logic [15:0] h_rdata,
    input  logic        s_valid,
    input  logic [15:0] s_addr,
    output logic        s_done,
    output logic [31:0] s_rdata,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wen,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata
);
    localparam int WW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {CL_NONE, CL_C, CL_H, CL_S} client_t;

    logic [WW-1:0] r_h_wait, r_s_wait;
    logic          r_h_busy, r_s_busy;
    client_t       r_pipe_id [RD_LAT];
    logic          r_pipe_rd [RD_LAT];

    client_t w_gnt;
    client_t w_tail_id;
    logic    w_tail_rd;
    logic    w_c_req, w_h_req, w_s_req;
    logic    w_h_starved, w_s_starved;
    logic    w_gnt_rd;

    assign w_tail_id = r_pipe_id[RD_LAT-1];
    assign w_tail_rd = r_pipe_rd[RD_LAT-1];

    // Busy drops in the done cycle so a held valid can be re-granted immediately.
    assign w_c_req = c_ren | (|c_wen);
    assign w_h_req = h_valid & ~(r_h_busy & (w_tail_id != CL_H));
    assign w_s_req = s_valid & ~(r_s_busy & (w_tail_id != CL_S));

    assign w_h_starved = (r_h_wait == WW'(STARVE_MAX));
    assign w_s_starved = (r_s_wait == WW'(STARVE_MAX));

    always_comb begin
        w_gnt = CL_NONE;
        if (!reset) begin
            if (w_h_req && w_h_starved)      w_gnt = CL_H;
            else if (w_s_req && w_s_starved) w_gnt = CL_S;
            else if (w_c_req)                w_gnt = CL_C;
            else if (w_h_req)                w_gnt = CL_H;
            else if (w_s_req)                w_gnt = CL_S;
        end
    end

    always_comb begin
        w_gnt_rd = 1'b0;
        case (w_gnt)
            CL_C:    w_gnt_rd = c_ren;
            CL_H:    w_gnt_rd = (h_wen == 2'b00);
            CL_S:    w_gnt_rd = 1'b1;
            default: w_gnt_rd = 1'b0;
        endcase
    end

    assign c_ready  = (w_gnt == CL_C) | ~w_c_req;
    assign c_rvalid = ~reset & (w_tail_id == CL_C) & w_tail_rd;
    assign h_done   = ~reset & (w_tail_id == CL_H);
    assign s_done   = ~reset & (w_tail_id == CL_S);
    assign h_rdata  = m_rdata[15:0];
    assign s_rdata  = m_rdata[31:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_wait <= '0;
            r_s_wait <= '0;
            r_h_busy <= 1'b0;
            r_s_busy <= 1'b0;
            m_addr   <= '0;
            m_wen    <= '0;
            m_wdata  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_id[i] <= CL_NONE;
                r_pipe_rd[i] <= 1'b0;
            end
        end else begin
            if (w_h_req && w_gnt != CL_H)
                r_h_wait <= w_h_starved ? r_h_wait : r_h_wait + 1'b1;
            else
                r_h_wait <= '0;
            if (w_s_req && w_gnt != CL_S)
                r_s_wait <= w_s_starved ? r_s_wait : r_s_wait + 1'b1;
            else
                r_s_wait <= '0;

            if (w_gnt == CL_H)           r_h_busy <= 1'b1;
            else if (w_tail_id == CL_H)  r_h_busy <= 1'b0;
            if (w_gnt == CL_S)           r_s_busy <= 1'b1;
            else if (w_tail_id == CL_S)  r_s_busy <= 1'b0;

            r_pipe_id[0] <= w_gnt;
            r_pipe_rd[0] <= w_gnt_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_id[i] <= r_pipe_id[i-1];
                r_pipe_rd[i] <= r_pipe_rd[i-1];
            end

            m_wen <= '0;
            case (w_gnt)
                CL_C: begin
                    m_addr  <= c_addr;
                    m_wen   <= c_wen;
                    m_wdata <= c_wdata;
                end
                CL_H: begin
                    m_addr  <= h_addr;
                    m_wen   <= {6'b0, h_wen};
                    m_wdata <= {48'b0, h_wdata};
                end
                CL_S: m_addr <= s_addr;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mlaccel_mem_arbiter.sv
// Bench for mlaccel_mem_arbiter: directed scenarios plus random traffic checked
// against a cycle-indexed reference model of grants, issue and completions.
module tb_mlaccel_mem_arbiter;
    localparam int RD_LAT = 2;
    localparam int SMAX   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        c_ren = 1'b0;
    logic [7:0]  c_wen = '0;
    logic [15:0] c_addr = '0;
    logic [63:0] c_wdata = '0;
    logic        c_ready, c_rvalid;
    logic        h_valid = 1'b0;
    logic [1:0]  h_wen = '0;
    logic [15:0] h_addr = '0;
    logic [15:0] h_wdata = '0;
    logic        h_done;
    logic [15:0] h_rdata;
    logic        s_valid = 1'b0;
    logic [15:0] s_addr = '0;
    logic        s_done;
    logic [31:0] s_rdata;
    logic [15:0] m_addr;
    logic [7:0]  m_wen;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata = '0;

    mlaccel_mem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(SMAX)) dut (
        .clock(clock), .reset(reset),
        .c_ren(c_ren), .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ready(c_ready), .c_rvalid(c_rvalid),
        .h_valid(h_valid), .h_wen(h_wen), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_done(h_done), .h_rdata(h_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_done(s_done), .s_rdata(s_rdata),
        .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clock = ~clock;

    // Memory attached to the arbiter: one-cycle registered read, read before write.
    logic [63:0] env_mem [256];
    always @(posedge clock) begin
        m_rdata <= env_mem[m_addr[7:0]];
        for (int b = 0; b < 8; b++)
            if (m_wen[b]) env_mem[m_addr[7:0]][b*8 +: 8] = m_wdata[b*8 +: 8];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // Reference model state: completions scheduled by absolute cycle number.
    int          cyc = 0;
    logic [63:0] ref_mem [256];
    int          h_wait = 0, s_wait = 0;
    int          h_due = -1, s_due = -1;
    logic        sc_c [8], sc_h [8], sc_s [8], sc_hrd [8], sc_crd [8];
    logic [63:0] sc_cd [8];
    logic [15:0] sc_hd [8];
    logic [31:0] sc_sd [8];
    logic [15:0] exp_addr = '0;
    logic [7:0]  exp_wen = '0;
    logic [63:0] exp_wdata = '0;
    logic        c_hold = 1'b0;
    logic [15:0] last_h_rdata = '0;

    task automatic tick();
        int   g, slot, nslot;
        logic c_req, h_req, s_req, cr_exp;
        c_req = c_ren | (|c_wen);
        h_req = h_valid && !(cyc < h_due);
        s_req = s_valid && !(cyc < s_due);
        g = 0;
        if (!reset) begin
            if (h_req && h_wait == SMAX)      g = 2;
            else if (s_req && s_wait == SMAX) g = 3;
            else if (c_req)                   g = 1;
            else if (h_req)                   g = 2;
            else if (s_req)                   g = 3;
        end
        cr_exp = (g == 1) || !c_req;
        #2;
        slot = cyc % 8;
        check_eq("c_ready", c_ready, cr_exp);
        check_eq("c_rvalid", c_rvalid, !reset && sc_c[slot] && sc_crd[slot]);
        check_eq("h_done", h_done, !reset && sc_h[slot]);
        check_eq("s_done", s_done, !reset && sc_s[slot]);
        check_eq("m_wen", m_wen, exp_wen);
        check_eq("m_addr", m_addr, exp_addr);
        check_eq("m_wdata", m_wdata, exp_wdata);
        if (!reset && sc_c[slot] && sc_crd[slot]) check_eq("c_rdata", m_rdata, sc_cd[slot]);
        if (!reset && sc_h[slot] && sc_hrd[slot]) check_eq("h_rdata", h_rdata, sc_hd[slot]);
        if (!reset && sc_s[slot]) check_eq("s_rdata", s_rdata, sc_sd[slot]);
        if (h_done) last_h_rdata = h_rdata;
        sc_c[slot] = 0; sc_h[slot] = 0; sc_s[slot] = 0;

        if (reset) begin
            for (int i = 0; i < 8; i++) begin sc_c[i] = 0; sc_h[i] = 0; sc_s[i] = 0; end
            h_wait = 0; s_wait = 0; h_due = -1; s_due = -1;
            exp_wen = '0; exp_addr = '0; exp_wdata = '0;
        end else begin
            h_wait = (h_req && g != 2) ? ((h_wait < SMAX) ? h_wait + 1 : SMAX) : 0;
            s_wait = (s_req && g != 3) ? ((s_wait < SMAX) ? s_wait + 1 : SMAX) : 0;
            nslot = (cyc + RD_LAT) % 8;
            exp_wen = '0;
            case (g)
                1: begin
                    exp_addr = c_addr; exp_wen = c_wen; exp_wdata = c_wdata;
                    sc_c[nslot] = 1; sc_crd[nslot] = c_ren;
                    sc_cd[nslot] = ref_mem[c_addr[7:0]];
                    for (int b = 0; b < 8; b++)
                        if (c_wen[b]) ref_mem[c_addr[7:0]][b*8 +: 8] = c_wdata[b*8 +: 8];
                end
                2: begin
                    exp_addr = h_addr; exp_wen = {6'b0, h_wen}; exp_wdata = {48'b0, h_wdata};
                    sc_h[nslot] = 1; sc_hrd[nslot] = (h_wen == 0);
                    sc_hd[nslot] = ref_mem[h_addr[7:0]][15:0];
                    if (h_wen[0]) ref_mem[h_addr[7:0]][7:0]  = h_wdata[7:0];
                    if (h_wen[1]) ref_mem[h_addr[7:0]][15:8] = h_wdata[15:8];
                    h_due = cyc + RD_LAT;
                end
                3: begin
                    exp_addr = s_addr;
                    sc_s[nslot] = 1; sc_sd[nslot] = ref_mem[s_addr[7:0]][31:0];
                    s_due = cyc + RD_LAT;
                end
                default: ;
            endcase
        end
        c_hold = c_req && !cr_exp;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic new_compute(input bit on);
        if (c_hold) return;
        c_ren = 1'b0; c_wen = '0;
        if (on) begin
            if ($urandom_range(0, 1) == 0) c_ren = 1'b1;
            else c_wen = 8'($urandom_range(1, 255));
        end
        c_addr  = 16'($urandom_range(0, 15));
        c_wdata = {$urandom, $urandom};
    endtask

    task automatic idle_inputs();
        c_ren = 0; c_wen = '0; h_valid = 0; s_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = {$urandom, $urandom};
            env_mem[i] = ref_mem[i];
        end
        for (int i = 0; i < 8; i++) begin
            sc_c[i] = 0; sc_h[i] = 0; sc_s[i] = 0; sc_hrd[i] = 0; sc_crd[i] = 0;
            sc_cd[i] = '0; sc_hd[i] = '0; sc_sd[i] = '0;
        end
        @(posedge clock); #1;
        // Requests present during reset must be ignored.
        reset = 1; c_ren = 1; h_valid = 1; s_valid = 1;
        tick(); tick();
        reset = 0; idle_inputs();
        tick();

        // Solo host write then read-back.
        h_valid = 1; h_wen = 2'd3; h_addr = 16'h0010; h_wdata = 16'hBEEF;
        tick(); tick();
        h_valid = 0; tick();
        h_valid = 1; h_wen = 2'd0;
        tick(); tick();
        h_valid = 0; tick();
        check_eq("beef_readback", last_h_rdata, 16'hBEEF);
        tick();

        // All three request together, compute idle afterwards.
        c_ren = 1; c_addr = 16'h0005; h_valid = 1; h_wen = 0; h_addr = 16'h0003;
        s_valid = 1; s_addr = 16'h0100;
        tick();
        c_ren = 0; tick(); tick();
        h_valid = 0; s_valid = 0;
        repeat (3) tick();

        // Compute saturates the port, host must be force-granted.
        h_valid = 1; h_wen = 2'd1; h_addr = 16'h0007; h_wdata = 16'h00A5;
        for (int i = 0; i < 10; i++) begin new_compute(1); tick(); end
        h_valid = 0;
        for (int i = 0; i < 3; i++) begin new_compute(1); tick(); end

        // Host and sequencer both starved.
        h_valid = 1; h_wen = 0; s_valid = 1; s_addr = 16'h0009;
        for (int i = 0; i < 10; i++) begin new_compute(1); tick(); end
        h_valid = 0; s_valid = 0;
        for (int i = 0; i < 3; i++) begin new_compute(1); tick(); end
        c_hold = 0; idle_inputs(); repeat (3) tick();

        // Reset while a fetch is in flight.
        s_valid = 1; s_addr = 16'h0020; tick();
        s_valid = 0; reset = 1; tick();
        reset = 0; tick();
        s_valid = 1; tick();
        s_valid = 0; repeat (3) tick();

        // Back-to-back sequencer fetches with one outstanding.
        s_valid = 1;
        for (int i = 0; i < 6; i++) begin s_addr = 16'(16'h0100 + i / 2); tick(); end
        s_valid = 0; repeat (2) tick();

        // Random traffic in phases of light and heavy compute load.
        for (int ph = 0; ph < 12; ph++) begin
            int cpct;
            cpct = (ph % 2 == 0) ? 30 : 95;
            for (int i = 0; i < 250; i++) begin
                reset = ($urandom_range(0, 299) == 0);
                new_compute($urandom_range(0, 99) < cpct);
                if ($urandom_range(0, 3) != 0) begin
                    h_valid = ($urandom_range(0, 99) < 60);
                    h_wen   = 2'($urandom_range(0, 3));
                    h_addr  = 16'($urandom_range(0, 15));
                    h_wdata = 16'($urandom);
                end
                if ($urandom_range(0, 3) != 0) begin
                    s_valid = ($urandom_range(0, 99) < 60);
                    s_addr  = 16'($urandom_range(0, 15));
                end
                tick();
            end
        end
        reset = 0; c_hold = 0; idle_inputs();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
